// File: rtl/fifo_ctrl_pkg.sv
// Shared helpers for the FIFO cell-ring controller: one-hot rotation, population count
// and the token reset value. Vectors are passed at TOK_MAXW and trimmed by the caller.
package fifo_ctrl_pkg;

   localparam int TOK_MAXW = 64;
   localparam logic [TOK_MAXW-1:0] TOK_RST = {{(TOK_MAXW-1){1'b0}}, 1'b1};

   // Rotate the low 'depth' bits left by one; bit depth-1 wraps to bit 0.
   function automatic logic [TOK_MAXW-1:0] rotl1(input logic [TOK_MAXW-1:0] vec,
                                                 input int depth);
      logic [TOK_MAXW-1:0] res;
      res = {TOK_MAXW{1'b0}};
      for (int i = 0; i < TOK_MAXW; i++) begin
         res[i] = (i < depth) ? vec[(i == 0) ? (depth - 1) : (i - 1)] : 1'b0;
      end
      return res;
   endfunction

   function automatic logic [7:0] popcount(input logic [TOK_MAXW-1:0] vec);
      logic [7:0] acc;
      acc = 8'd0;
      for (int i = 0; i < TOK_MAXW; i++) begin
         acc = acc + {7'd0, vec[i]};
      end
      return acc;
   endfunction

endpackage

// File: rtl/fifo_token_ring.sv
// One-hot token register that starts on cell 0 and steps one cell round the ring on each adv.
module fifo_token_ring
   import fifo_ctrl_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             adv,
   output logic [DEPTH-1:0] tok
);

   logic [DEPTH-1:0]    tok_q;
   logic [DEPTH-1:0]    tok_d;
   logic [TOK_MAXW-1:0] tok_ext_s;

   // Next token: rotated copy when advancing, otherwise hold.
   always_comb begin
      tok_ext_s = {TOK_MAXW{1'b0}};
      tok_ext_s[DEPTH-1:0] = tok_q;
      if (adv) begin
         tok_d = DEPTH'(rotl1(tok_ext_s, DEPTH));
      end else begin
         tok_d = tok_q;
      end
   end

   // Token register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tok_q <= TOK_RST[DEPTH-1:0];
      end else begin
         tok_q <= tok_d;
      end
   end

   assign tok = tok_q;

endmodule

// File: rtl/fifo_cell_ring_ctrl.sv
// Validity controller for a ring of DEPTH data cells: accept logic, per-cell strobes,
// occupancy count, threshold flags and sticky request-error flags.
module fifo_cell_ring_ctrl
   import fifo_ctrl_pkg::*;
#(
   parameter int  DEPTH    = 4,
   parameter int  AF_LEVEL = 3,
   parameter int  AE_LEVEL = 1,
   localparam int CW       = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_put,
   input  logic             req_get,
   output logic             put_ack,
   output logic             get_ack,
   output logic [DEPTH-1:0] we,
   output logic [DEPTH-1:0] re,
   output logic [DEPTH-1:0] ptok,
   output logic [DEPTH-1:0] gtok,
   output logic [DEPTH-1:0] cell_valid,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             almost_empty,
   output logic [CW-1:0]    count,
   output logic             put_err,
   output logic             get_err
);

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
   localparam logic [CW-1:0] ONE_C   = CW'(1);

   logic [DEPTH-1:0] cell_valid_q, cell_valid_d;
   logic [CW-1:0]    count_q, count_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             af_q, af_d;
   logic             ae_q, ae_d;
   logic             put_err_q, put_err_d;
   logic             get_err_q, get_err_d;
   logic             put_ack_s, get_ack_s;

   fifo_token_ring #(.DEPTH(DEPTH)) u_put_ring (
      .clk   (clk),
      .rst_n (rst_n),
      .adv   (put_ack_s),
      .tok   (ptok)
   );

   fifo_token_ring #(.DEPTH(DEPTH)) u_get_ring (
      .clk   (clk),
      .rst_n (rst_n),
      .adv   (get_ack_s),
      .tok   (gtok)
   );

   // Acks look only at registered state; rst_n gating drops them while reset is held.
   always_comb begin
      put_ack_s = rst_n & req_put & ~(|(cell_valid_q & ptok));
      get_ack_s = rst_n & req_get & (|(cell_valid_q & gtok));
   end

   // Next state for valid bits, count, flags and sticky errors.
   always_comb begin
      cell_valid_d = (cell_valid_q | (ptok & {DEPTH{put_ack_s}})) & ~(gtok & {DEPTH{get_ack_s}});
      count_d      = count_q;
      if (put_ack_s && !get_ack_s) begin
         count_d = count_q + ONE_C;
      end else if (get_ack_s && !put_ack_s) begin
         count_d = count_q - ONE_C;
      end else begin
         count_d = count_q;
      end
      full_d    = (count_d == DEPTH_C);
      empty_d   = (count_d == {CW{1'b0}});
      af_d      = (count_d >= AF_C);
      ae_d      = (count_d <= AE_C);
      // A request that loses a full/empty collision is a hold, not an error.
      put_err_d = put_err_q | (req_put & full_q & ~req_get);
      get_err_d = get_err_q | (req_get & empty_q & ~req_put);
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cell_valid_q <= {DEPTH{1'b0}};
         count_q      <= {CW{1'b0}};
         full_q       <= 1'b0;
         empty_q      <= 1'b1;
         af_q         <= 1'b0;
         ae_q         <= 1'b1;
         put_err_q    <= 1'b0;
         get_err_q    <= 1'b0;
      end else begin
         cell_valid_q <= cell_valid_d;
         count_q      <= count_d;
         full_q       <= full_d;
         empty_q      <= empty_d;
         af_q         <= af_d;
         ae_q         <= ae_d;
         put_err_q    <= put_err_d;
         get_err_q    <= get_err_d;
      end
   end

   assign put_ack      = put_ack_s;
   assign get_ack      = get_ack_s;
   assign we           = ptok & {DEPTH{put_ack_s}};
   assign re           = gtok & {DEPTH{get_ack_s}};
   assign cell_valid   = cell_valid_q;
   assign count        = count_q;
   assign full         = full_q;
   assign empty        = empty_q;
   assign almost_full  = af_q;
   assign almost_empty = ae_q;
   assign put_err      = put_err_q;
   assign get_err      = get_err_q;

endmodule
